// File: rtl/stall_sequencer.sv
// stall_sequencer: merges prioritized multi-source stall requests into one registered stall episode
// Optional STALL_PERF_EN adds perf_cycles/perf_events counters
module stall_sequencer #(
  parameter int N_SRC = 4,
  parameter int CNT_W = 4,
  parameter int DEF_LEN = 2,
  localparam int SRC_W = N_SRC > 1 ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       req,
  input  logic [N_SRC*CNT_W-1:0] req_len,
  input  logic                   hold,
  output logic                   stall,
  output logic                   stall_start,
  output logic [SRC_W-1:0]       stall_src,
  output logic [CNT_W-1:0]       busy_cnt
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]            perf_cycles,
  output logic [15:0]            perf_events
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  logic [1:0] state;
  logic [CNT_W-1:0] max_m1, cnt_dec, merged;
  logic [SRC_W-1:0] win;
  logic any;
  function automatic logic [CNT_W-1:0] eff_m1(input logic [CNT_W-1:0] l);
    return l == '0 ? CNT_W'(DEF_LEN - 1) : l - 1'b1;
  endfunction
  assign any = |req;
  assign cnt_dec = busy_cnt - 1'b1;
  assign merged = max_m1 > cnt_dec ? max_m1 : cnt_dec;
  // descending scan so the lowest set index is the last winner written
  always_comb begin
    max_m1 = '0;
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        win = SRC_W'(i);
        max_m1 = eff_m1(req_len[i*CNT_W +: CNT_W]) > max_m1 ? eff_m1(req_len[i*CNT_W +: CNT_W]) : max_m1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      stall <= 1'b0;
      stall_start <= 1'b0;
      stall_src <= '0;
      busy_cnt <= '0;
    end else begin
      stall_start <= 1'b0;
      case (state)
        IDLE: if (any) begin
          state <= COUNT;
          stall <= 1'b1;
          stall_start <= 1'b1;
          stall_src <= win;
          busy_cnt <= max_m1;
        end
        COUNT: if (busy_cnt != '0) busy_cnt <= merged;
          else if (any) busy_cnt <= max_m1;
          else if (hold) state <= HOLD;
          else begin
            stall <= 1'b0;
            state <= IDLE;
          end
        HOLD: if (any) begin
          busy_cnt <= max_m1;
          state <= COUNT;
        end else if (!hold) begin
          stall <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
          busy_cnt <= '0;
        end
      endcase
    end
  end
`ifdef STALL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_events <= '0;
    end else begin
      perf_cycles <= perf_cycles + 32'(stall);
      perf_events <= perf_events + 16'(stall_start);
    end
  end
`endif
endmodule

// File: tb/tb_stall_sequencer.sv
// tb_stall_sequencer: directed vector table, hand sequences and randomized timeline-model checks
module tb_stall_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [15:0] req_len = '0;
  logic hold = 1'b0;
  logic stall, stall_start;
  logic [1:0] stall_src;
  logic [3:0] busy_cnt;
`ifdef STALL_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_events;
`endif
  int vecs = 0;
  int errs = 0;
  stall_sequencer dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_len(req_len),
    .hold(hold),
    .stall(stall),
    .stall_start(stall_start),
    .stall_src(stall_src),
    .busy_cnt(busy_cnt)
`ifdef STALL_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_events(perf_events)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] req;
    logic [15:0] len;
    logic hold;
    logic st;
    logic ss;
    logic [1:0] src;
    logic [3:0] busy;
    string nm;
  } vec_t;
  vec_t tbl[$];
  // Timeline model: stall is high after edge k while k <= end_e
  int k = 0;
  int end_e = -1;
  bit m_stall, m_start;
  int m_src, m_busy;
  function automatic void model_reset();
    end_e = k - 1;
    m_stall = 0;
    m_start = 0;
    m_src = 0;
    m_busy = 0;
  endfunction
  function automatic void model_step(logic [3:0] r, logic [15:0] l, logic h);
    int mx = 0;
    int w = -1;
    int e;
    bit prev = m_stall;
    k++;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        e = (l[i*4 +: 4] == 4'd0) ? 2 : int'(l[i*4 +: 4]);
        if (e > mx) mx = e;
        if (w < 0) w = i;
      end
    end
    if (mx > 0) begin
      if (k + mx - 1 > end_e) end_e = k + mx - 1;
    end else if (prev && k > end_e && h) end_e = k;
    m_stall = k <= end_e;
    m_start = m_stall && !prev;
    if (m_start) m_src = w;
    m_busy = m_stall ? end_e - k : 0;
  endfunction
  task automatic check(input string nm, input logic es, input logic est, input logic [1:0] esrc,
                       input logic [3:0] eb, input logic src_chk);
    vecs++;
    if (stall !== es || stall_start !== est || busy_cnt !== eb || (src_chk && stall_src !== esrc)) begin
      errs++;
      $display("FAIL %s @%0t: got stall=%b start=%b src=%0d busy=%0d, want stall=%b start=%b src=%0d busy=%0d",
               nm, $time, stall, stall_start, stall_src, busy_cnt, es, est, esrc, eb);
    end
  endtask
  initial begin
    logic do_rst;
    tbl.push_back('{4'b0001, 16'h0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'd1, "t1_a"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, "t1_b"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, "t1_end"});
    tbl.push_back('{4'b0100, 16'h0500, 1'b0, 1'b1, 1'b1, 2'd2, 4'd4, "t2_a"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd2, 4'd3, "t2_b"});
    tbl.push_back('{4'b0010, 16'h0530, 1'b0, 1'b1, 1'b0, 2'd2, 4'd2, "t2_merge"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd2, 4'd1, "t2_c"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd2, 4'd0, "t2_d"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, "t2_end"});
    tbl.push_back('{4'b1010, 16'h4010, 1'b0, 1'b1, 1'b1, 2'd1, 4'd3, "t3_a"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'd2, "t3_b"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'd1, "t3_c"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'd0, "t3_d"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, "t3_end"});
    tbl.push_back('{4'b0001, 16'h0002, 1'b1, 1'b1, 1'b1, 2'd0, 4'd1, "t4_a"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, "t4_b"});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{4'b0000, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, "t4_hold"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, "t4_end"});
    tbl.push_back('{4'b0001, 16'h0003, 1'b0, 1'b1, 1'b1, 2'd0, 4'd2, "t5_a"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1, "t5_b"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, "t5_c"});
    tbl.push_back('{4'b0001, 16'h0003, 1'b0, 1'b1, 1'b0, 2'd0, 4'd2, "t5_reload"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1, "t5_d"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, "t5_e"});
    tbl.push_back('{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, "t5_end"});
    @(posedge clk);
    #1 check("reset", 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) begin
      @(negedge clk);
      req = tbl[i].req;
      req_len = tbl[i].len;
      hold = tbl[i].hold;
      @(posedge clk);
      #1 check(tbl[i].nm, tbl[i].st, tbl[i].ss, tbl[i].src, tbl[i].busy, tbl[i].st);
    end
    // async reset in the middle of a counting episode
    @(negedge clk);
    req = 4'b0001;
    req_len = 16'h0005;
    @(posedge clk);
    #1 check("t6_pre", 1'b1, 1'b1, 2'd0, 4'd4, 1'b1);
    #2 rst = 1'b1;
    #1 check("t6_rst", 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
`ifdef STALL_PERF_EN
    vecs++;
    if (perf_cycles !== 32'd0 || perf_events !== 16'd0) begin
      errs++;
      $display("FAIL perf_rst: got cycles=%0d events=%0d, want 0 0", perf_cycles, perf_events);
    end
`endif
    @(negedge clk);
    req = '0;
    req_len = '0;
    rst = 1'b0;
    @(posedge clk);
    #1 check("t6_after", 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
`ifdef STALL_PERF_EN
    @(negedge clk);
    req = 4'b0001;
    req_len = 16'h0003;
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
    vecs++;
    if (perf_cycles !== 32'd3 || perf_events !== 16'd1) begin
      errs++;
      $display("FAIL perf_cnt: got cycles=%0d events=%0d, want 3 1", perf_cycles, perf_events);
    end
`endif
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      do_rst = ($urandom_range(0, 199) == 0);
      rst = do_rst;
      for (int i = 0; i < 4; i++) req[i] = ($urandom_range(0, 7) == 0);
      req_len = 16'($urandom);
      if ($urandom_range(0, 9) == 0) hold = ~hold;
      @(posedge clk);
      #1;
      if (do_rst) begin
        model_reset();
        check("rand_rst", 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
      end else begin
        model_step(req, req_len, hold);
        check("rand", m_stall, m_start, 2'(m_src), 4'(m_busy), m_stall);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
